onchip_mem_copy_master: RTL and testbench

- Avalon-MM master that copies a block of 32-bit words inside the on-chip memory: it reads a source word, then writes that word to the destination, one word at a time.
- Sits on the second memory port (s2) so sprite and frame buffers can be moved without the Nios II CPU.
- A simple start/busy/done sideband interface controls it; the CPU drives that interface through a PIO or register shim.

---
 rtl/onchip_mem_copy_master_pkg.sv | 16 +
 rtl/onchip_mem_copy_master.sv | 121 ++++++++++++
 tb/tb_onchip_mem_copy_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_copy_master_pkg.sv
// Shared types and constants for the on-chip memory copy master.
// State encoding and the all-ones byteenable pattern.
package onchip_mem_copy_master_pkg;

  localparam int ST_W = 3;
  localparam logic [127:0] BE_ALL = '1;

  typedef enum logic [ST_W-1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } copy_state_t;

endpackage

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master copying a block of words, one read then one
// write per word, controlled by a start/busy/done sideband.
module onchip_mem_copy_master
  import onchip_mem_copy_master_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LEN_W-1:0]    words_done,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest,
  input  logic                m_readdatavalid
);

  localparam int BE_W = DATA_W / 8;

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              ab_q, ab_d;
  logic              last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      ab_q    <= ab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    ab_d    = ab_q;
    last    = (cnt_q + LEN_W'(1)) == len_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          cnt_d   = '0;
          ab_d    = 1'b0;
          state_d = (length == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!m_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (m_readdatavalid) begin
          buf_d   = m_readdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        // Abort is only honoured once the write has been accepted.
        if (!m_waitrequest) begin
          cnt_d = cnt_q + LEN_W'(1);
          src_d = src_q + ADDR_W'(1);
          dst_d = dst_q + ADDR_W'(1);
          if (last || abort) begin
            state_d = FINISH;
            ab_d    = abort && !last;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy         = state_q inside {RD_REQ, RD_WAIT, WR_REQ};
  assign done         = state_q == FINISH;
  assign aborted      = ab_q;
  assign words_done   = cnt_q;
  assign m_read       = state_q == RD_REQ;
  assign m_write      = state_q == WR_REQ;
  assign m_address    = m_read  ? src_q :
                        m_write ? dst_q : '0;
  assign m_byteenable = (m_read || m_write) ? BE_ALL[BE_W-1:0] : '0;
  assign m_writedata  = buf_q;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Scoreboard bench for the memory copy master: a memory model
// answers the bus, a monitor pops expected reads/writes/dones.
module tb_onchip_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [15:0] src_addr, dst_addr, length;
  logic        busy, done, aborted;
  logic [15:0] words_done, m_address;
  logic        m_read, m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata, m_readdata;
  logic        m_waitrequest, m_readdatavalid;

  onchip_mem_copy_master dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .aborted(aborted),
    .words_done(words_done), .m_address(m_address),
    .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .m_readdatavalid(m_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int words; bit ab; int lat; } dn_t;

  logic [31:0] mem [0:65535];
  logic [15:0] rdq [$];
  wr_t         wrq [$];
  dn_t         dnq [$];

  int checks = 0;
  int errors = 0;
  bit bp = 1'b0;
  int lat = 1;
  int rd_cnt = 0;
  logic [15:0] rd_addr = '0;
  bit stall_q = 1'b0;
  logic [49:0] snap = '0;
  int cyc = 0;
  int t0 = 0;
  int nreads = 0;
  int dones = 0;

  logic [31:0] vals [0:3];

  always @(negedge clk) begin : mon
    bit wr;
    logic [15:0] ea;
    wr_t ew;
    dn_t ed;
    cyc++;
    if (reset) begin
      rd_cnt = 0;
      stall_q = 1'b0;
      m_readdatavalid = 1'b0;
      m_waitrequest = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if ({m_address, m_read, m_write, m_writedata} !== snap) begin
          errors++;
          $display("FAIL stall_hold got %h required %h",
                   {m_address, m_read, m_write, m_writedata}, snap);
        end
      end
      checks++;
      if (m_byteenable !== ((m_read || m_write) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL byteenable got %h rd %b wr %b",
                 m_byteenable, m_read, m_write);
      end
      m_readdatavalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          m_readdatavalid = 1'b1;
          m_readdata = mem[rd_addr];
        end
      end
      if (start && !busy && !done) t0 = cyc;
      if (done) begin
        checks++;
        dones++;
        if (dnq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done words %0d", words_done);
        end else begin
          ed = dnq.pop_front();
          if (int'(words_done) != ed.words || aborted !== ed.ab ||
              (ed.lat >= 0 && cyc - t0 != ed.lat)) begin
            errors++;
            $display("FAIL done got w=%0d ab=%b lat=%0d required w=%0d ab=%b lat=%0d",
                     words_done, aborted, cyc - t0, ed.words, ed.ab, ed.lat);
          end
        end
      end
      wr = bp ? 1'($urandom_range(0, 1)) : 1'b0;
      m_waitrequest = wr;
      if (m_read && !wr) begin
        checks++;
        nreads++;
        if (rdq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read addr %h", m_address);
        end else begin
          ea = rdq.pop_front();
          if (m_address !== ea) begin
            errors++;
            $display("FAIL read_addr got %h required %h", m_address, ea);
          end
        end
        rd_addr = m_address;
        rd_cnt = lat;
      end
      if (m_write && !wr) begin
        checks++;
        mem[m_address] = m_writedata;
        if (wrq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr %h data %h",
                   m_address, m_writedata);
        end else begin
          ew = wrq.pop_front();
          if (m_address !== ew.addr || m_writedata !== ew.data) begin
            errors++;
            $display("FAIL write got %h:%h required %h:%h",
                     m_address, m_writedata, ew.addr, ew.data);
          end
        end
      end
      stall_q = (m_read || m_write) && wr;
      snap = {m_address, m_read, m_write, m_writedata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic go(input logic [15:0] s, input logic [15:0] d,
                    input logic [15:0] n);
    tick();
    src_addr = s;
    dst_addr = d;
    length = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = dones;
    k = 0;
    while (dones == d0 && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (dones == d0) begin
      errors++;
      $display("FAIL done_timeout got none required pulse");
    end
  endtask

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d,
                           input int n);
    for (int i = 0; i < n; i++) begin
      rdq.push_back(s + 16'(i));
      wrq.push_back('{addr: d + 16'(i), data: mem[s + 16'(i)]});
    end
  endtask

  initial begin : stim
    int k;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    vals[0] = 32'hA0A0_0000;
    vals[1] = 32'hA1A1_1111;
    vals[2] = 32'hA2A2_2222;
    vals[3] = 32'hA3A3_3333;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    m_readdata = '0;
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_aborted", 64'(aborted), 64'(0));
    chk("rst_bus", 64'({m_read, m_write, m_byteenable}), 64'(0));
    chk("rst_words", 64'(words_done), 64'(0));
    chk("rst_addr_data", 64'({m_address, m_writedata}), 64'(0));
    tick();
    reset = 1'b0;

    // basic copy: 12 busy cycles then done
    for (int i = 0; i < 4; i++) mem[16'h0100 + 16'(i)] = vals[i];
    for (int i = 0; i < 4; i++) begin
      rdq.push_back(16'h0100 + 16'(i));
      wrq.push_back('{addr: 16'h0200 + 16'(i), data: vals[i]});
    end
    dnq.push_back('{words: 4, ab: 1'b0, lat: 13});
    go(16'h0100, 16'h0200, 16'd4);
    wait_done(100);
    tick();
    chk("words_hold", 64'(words_done), 64'(4));
    chk("mem_0203", 64'(mem[16'h0203]), 64'(32'hA3A3_3333));

    // zero length
    dnq.push_back('{words: 0, ab: 1'b0, lat: 1});
    go(16'h0100, 16'h0300, 16'd0);
    wait_done(20);
    tick();
    chk("zero_words", 64'(words_done), 64'(0));

    // wrap-around of the source pointer
    mem[16'hFFFE] = 32'hBEEF_0001;
    mem[16'hFFFF] = 32'hBEEF_0002;
    mem[16'h0000] = 32'hBEEF_0003;
    mem[16'h0001] = 32'hBEEF_0004;
    rdq.push_back(16'hFFFE);
    rdq.push_back(16'hFFFF);
    rdq.push_back(16'h0000);
    rdq.push_back(16'h0001);
    wrq.push_back('{addr: 16'h0010, data: 32'hBEEF_0001});
    wrq.push_back('{addr: 16'h0011, data: 32'hBEEF_0002});
    wrq.push_back('{addr: 16'h0012, data: 32'hBEEF_0003});
    wrq.push_back('{addr: 16'h0013, data: 32'hBEEF_0004});
    dnq.push_back('{words: 4, ab: 1'b0, lat: 13});
    go(16'hFFFE, 16'h0010, 16'd4);
    wait_done(100);

    // backpressure, read latency 3, ignored start while busy
    for (int i = 0; i < 8; i++) mem[16'h0500 + 16'(i)] = 32'h5A5A_0000 + 32'(i * 17);
    push_copy(16'h0500, 16'h0600, 8);
    dnq.push_back('{words: 8, ab: 1'b0, lat: -1});
    bp = 1'b1;
    lat = 3;
    go(16'h0500, 16'h0600, 16'd8);
    repeat (5) tick();
    src_addr = 16'h0700;
    dst_addr = 16'h0800;
    length = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2000);
    tick();
    bp = 1'b0;
    lat = 1;
    tick();
    chk("bp_mem_0607", 64'(mem[16'h0607]), 64'(32'h5A5A_0077));

    // abort during the 4th read
    for (int i = 0; i < 10; i++) mem[16'h0300 + 16'(i)] = 32'hC0DE_0000 + 32'(i);
    push_copy(16'h0300, 16'h0400, 4);
    dnq.push_back('{words: 4, ab: 1'b1, lat: 13});
    k = nreads;
    go(16'h0300, 16'h0400, 16'd10);
    for (int i = 0; i < 100 && nreads < k + 4; i++) tick();
    chk("abort_reads_seen", 64'(nreads - k), 64'(4));
    abort = 1'b1;
    wait_done(100);
    abort = 1'b0;
    repeat (6) tick();
    chk("abort_idle", 64'({busy, m_read}), 64'(0));

    // reset during the write of word 2
    for (int i = 0; i < 4; i++) mem[16'h0700 + 16'(i)] = 32'h7777_0000 + 32'(i);
    rdq.push_back(16'h0700);
    rdq.push_back(16'h0701);
    wrq.push_back('{addr: 16'h0800, data: 32'h7777_0000});
    go(16'h0700, 16'h0800, 16'd4);
    k = 0;
    while (!(m_write && words_done == 16'd1) && k < 100) begin
      tick();
      k++;
    end
    chk("rst_reach_wr2", 64'(m_write), 64'(1));
    reset = 1'b1;
    #1;
    chk("rst_async_write", 64'(m_write), 64'(0));
    chk("rst_async_busy", 64'(busy), 64'(0));
    tick();
    tick();
    chk("rst_words_clr", 64'(words_done), 64'(0));
    reset = 1'b0;
    tick();
    rdq.push_back(16'h0100);
    rdq.push_back(16'h0101);
    wrq.push_back('{addr: 16'h0900, data: vals[0]});
    wrq.push_back('{addr: 16'h0901, data: vals[1]});
    dnq.push_back('{words: 2, ab: 1'b0, lat: 7});
    go(16'h0100, 16'h0900, 16'd2);
    wait_done(100);
    repeat (4) tick();

    chk("queues_empty", 64'(rdq.size() + wrq.size() + dnq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
